// File: rtl/lsu_pkg.sv
// Shared constants, state encoding and access-legality helper for the load/store unit.
package lsu_pkg;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;
  localparam logic [2:0] F3_SB  = 3'd0;
  localparam logic [2:0] F3_SH  = 3'd1;
  localparam logic [2:0] F3_SW  = 3'd2;

  localparam int IO_SEL_BIT_DEFAULT = 10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_READ_WAIT,
    S_RESP
  } lsu_state_e;

  // True when the access must never reach memory: bad width code or misaligned address.
  function automatic logic access_rejected(input logic       is_store,
                                           input logic [2:0] funct3,
                                           input logic [1:0] byte_off);
    logic bad;
    bad = 1'b0;
    if (is_store) begin
      case (funct3)
        F3_SB:   bad = 1'b0;
        F3_SH:   bad = byte_off[0];
        F3_SW:   bad = (byte_off != 2'b00);
        default: bad = 1'b1;
      endcase
    end else begin
      case (funct3)
        F3_LB, F3_LBU: bad = 1'b0;
        F3_LH, F3_LHU: bad = byte_off[0];
        F3_LW:         bad = (byte_off != 2'b00);
        default:       bad = 1'b1;
      endcase
    end
    return bad;
  endfunction

endpackage

// File: rtl/load_store_unit_load_align.sv
// Extracts the addressed byte/halfword from a read word and sign- or zero-extends it.
module load_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  byte_off,
  input  logic [31:0] word,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (byte_off)
      2'd0:    byte_sel = word[7:0];
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      default: byte_sel = word[31:24];
    endcase
    half_sel = byte_off[1] ? word[31:16] : word[15:0];

    case (funct3)
      F3_LB:   data = {{24{byte_sel[7]}}, byte_sel};
      F3_LBU:  data = {24'd0, byte_sel};
      F3_LH:   data = {{16{half_sel[15]}}, half_sel};
      F3_LHU:  data = {16'd0, half_sel};
      F3_LW:   data = word;
      default: data = 32'd0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store sequencer in front of the data-memory stage.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int IO_SEL_BIT = IO_SEL_BIT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic [3:0]  mem_bank_en,
  output logic        mem_re,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_stalln,
  input  logic [31:0] mem_rdata,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        misalign,
  output logic        proto_err
);

  lsu_state_e  state_q, state_d;
  logic        store_q, store_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] rdata_q, rdata_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic [31:0] wb_hold_q, wb_hold_d;
  logic        proto_err_q, proto_err_d;

  logic        reject;
  logic [31:0] word_addr;
  logic [31:0] wdata_sb;
  logic [31:0] wdata_sh;
  logic [31:0] align_out;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_sb_lane
      assign wdata_sb[8*gi +: 8] = wdata_q[7:0];
    end
    for (gi = 0; gi < 2; gi++) begin : g_sh_lane
      assign wdata_sh[16*gi +: 16] = wdata_q[15:0];
    end
  endgenerate

  assign word_addr = {addr_q[31:2], 2'b00};
  assign reject    = access_rejected(store_q, funct3_q, addr_q[1:0]);

  load_align u_load_align (
    .funct3   (funct3_q),
    .byte_off (addr_q[1:0]),
    .word     (rdata_q),
    .data     (align_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      store_q     <= 1'b0;
      funct3_q    <= 3'd0;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
      rd_q        <= 5'd0;
      rdata_q     <= 32'd0;
      wb_rd_q     <= 5'd0;
      wb_hold_q   <= 32'd0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      store_q     <= store_d;
      funct3_q    <= funct3_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rd_q        <= rd_d;
      rdata_q     <= rdata_d;
      wb_rd_q     <= wb_rd_d;
      wb_hold_q   <= wb_hold_d;
      proto_err_q <= proto_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    store_d     = store_q;
    funct3_d    = funct3_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rd_d        = rd_q;
    rdata_d     = rdata_q;
    wb_rd_d     = wb_rd_q;
    wb_hold_d   = wb_hold_q;
    proto_err_d = proto_err_q;

    req_ready   = 1'b0;
    mem_bank_en = 4'b0000;
    mem_re      = 1'b0;
    mem_addr    = 32'd0;
    mem_wdata   = 32'd0;
    wb_valid    = 1'b0;
    wb_rd       = wb_rd_q;
    wb_data     = wb_hold_q;
    misalign    = 1'b0;

    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          store_d  = req_store;
          funct3_d = req_funct3;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          rd_d     = req_rd;
          state_d  = S_ISSUE;
        end
      end

      S_ISSUE: begin
        if (reject) begin
          state_d = S_RESP;
        end else if (store_q) begin
          mem_addr = word_addr;
          case (funct3_q)
            F3_SB: begin
              mem_bank_en = 4'b0001 << addr_q[1:0];
              mem_wdata   = wdata_sb;
            end
            F3_SH: begin
              mem_bank_en = 4'b0011 << addr_q[1:0];
              mem_wdata   = wdata_sh;
            end
            default: begin
              mem_bank_en = 4'b1111;
              mem_wdata   = wdata_q;
            end
          endcase
          state_d = S_IDLE;
        end else begin
          mem_re   = 1'b1;
          mem_addr = word_addr;
          state_d  = S_READ_WAIT;
        end
      end

      S_READ_WAIT: begin
        mem_re   = 1'b1;
        mem_addr = word_addr;
        rdata_d  = mem_rdata;
        wb_rd_d  = rd_q;
        // RAM reads always take a stall cycle; IO reads may legitimately not.
        if (!addr_q[IO_SEL_BIT] && mem_stalln) begin
          proto_err_d = 1'b1;
        end
        state_d = S_RESP;
      end

      S_RESP: begin
        if (reject) begin
          misalign = 1'b1;
        end else begin
          wb_valid  = 1'b1;
          wb_data   = align_out;
          wb_hold_d = align_out;
        end
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign proto_err = proto_err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed-vector bench for load_store_unit with hand-computed expectations.
module tb_load_store_unit;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [4:0]  req_rd;
  logic [3:0]  mem_bank_en;
  logic        mem_re;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_stalln;
  logic [31:0] mem_rdata;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        misalign;
  logic        proto_err;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  load_store_unit dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_store   (req_store),
    .req_funct3  (req_funct3),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .req_rd      (req_rd),
    .mem_bank_en (mem_bank_en),
    .mem_re      (mem_re),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_stalln  (mem_stalln),
    .mem_rdata   (mem_rdata),
    .wb_valid    (wb_valid),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data),
    .misalign    (misalign),
    .proto_err   (proto_err)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Presents one request in IDLE; returns at the falling edge of the ISSUE cycle.
  task automatic start_req(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [4:0] rd);
    @(negedge clk);
    check_val("ready_before_accept", {31'd0, req_ready}, 32'd1);
    req_valid  = 1'b1;
    req_store  = st;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    req_rd     = rd;
    @(negedge clk);
    req_valid  = 1'b0;
    req_wdata  = 32'h0;
  endtask

  task automatic do_store(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [3:0] exp_be, input logic [31:0] exp_wd);
    start_req(1'b1, f3, addr, wd, 5'd0);
    $display("store %s addr=0x%08h be=%b wdata=0x%08h", tag, addr, mem_bank_en, mem_wdata);
    check_val({tag, "_be"}, {28'd0, mem_bank_en}, {28'd0, exp_be});
    check_val({tag, "_wdata"}, mem_wdata, exp_wd);
    check_val({tag, "_addr"}, mem_addr, {addr[31:2], 2'b00});
    check_val({tag, "_re"}, {31'd0, mem_re}, 32'd0);
    @(negedge clk);
    check_val({tag, "_ready_n2"}, {31'd0, req_ready}, 32'd1);
    check_val({tag, "_be_off"}, {28'd0, mem_bank_en}, 32'd0);
  endtask

  task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] rdata, input logic [4:0] rd, input logic stalln,
                         input logic [31:0] exp_data);
    start_req(1'b0, f3, addr, 32'h0, rd);
    check_val({tag, "_re_issue"}, {31'd0, mem_re}, 32'd1);
    check_val({tag, "_be_issue"}, {28'd0, mem_bank_en}, 32'd0);
    check_val({tag, "_addr"}, mem_addr, {addr[31:2], 2'b00});
    @(negedge clk);
    check_val({tag, "_re_wait"}, {31'd0, mem_re}, 32'd1);
    mem_rdata  = rdata;
    mem_stalln = stalln;
    @(negedge clk);
    mem_stalln = 1'b1;
    mem_rdata  = 32'h0BAD_0BAD;
    $display("load %s addr=0x%08h wb_valid=%0b wb_rd=%0d wb_data=0x%08h", tag, addr, wb_valid, wb_rd, wb_data);
    check_val({tag, "_wb_valid"}, {31'd0, wb_valid}, 32'd1);
    check_val({tag, "_wb_data"}, wb_data, exp_data);
    check_val({tag, "_wb_rd"}, {27'd0, wb_rd}, {27'd0, rd});
    check_val({tag, "_ready_resp"}, {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    check_val({tag, "_wb_pulse_end"}, {31'd0, wb_valid}, 32'd0);
    check_val({tag, "_wb_hold"}, wb_data, exp_data);
    check_val({tag, "_ready_n4"}, {31'd0, req_ready}, 32'd1);
  endtask

  task automatic do_reject(input string tag, input logic st, input logic [2:0] f3,
                           input logic [31:0] addr);
    start_req(st, f3, addr, 32'hFFFF_FFFF, 5'd9);
    check_val({tag, "_re_issue"}, {31'd0, mem_re}, 32'd0);
    check_val({tag, "_be_issue"}, {28'd0, mem_bank_en}, 32'd0);
    @(negedge clk);
    $display("reject %s addr=0x%08h misalign=%0b wb_valid=%0b", tag, addr, misalign, wb_valid);
    check_val({tag, "_misalign"}, {31'd0, misalign}, 32'd1);
    check_val({tag, "_no_wb"}, {31'd0, wb_valid}, 32'd0);
    check_val({tag, "_re_resp"}, {31'd0, mem_re}, 32'd0);
    check_val({tag, "_be_resp"}, {28'd0, mem_bank_en}, 32'd0);
    @(negedge clk);
    check_val({tag, "_misalign_end"}, {31'd0, misalign}, 32'd0);
    check_val({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_store  = 1'b0;
    req_funct3 = 3'd0;
    req_addr   = 32'd0;
    req_wdata  = 32'd0;
    req_rd     = 5'd0;
    mem_stalln = 1'b1;
    mem_rdata  = 32'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    check_val("rst_ready", {31'd0, req_ready}, 32'd1);
    check_val("rst_re", {31'd0, mem_re}, 32'd0);
    check_val("rst_be", {28'd0, mem_bank_en}, 32'd0);
    check_val("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    check_val("rst_wb_data", wb_data, 32'd0);
    check_val("rst_proto_err", {31'd0, proto_err}, 32'd0);
    check_val("rst_misalign", {31'd0, misalign}, 32'd0);

    do_store("sw", F3_SW, 32'h0000_0008, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF);
    do_store("sb", F3_SB, 32'h0000_0003, 32'h0000_00A5, 4'b1000, 32'hA5A5_A5A5);
    do_store("sh", F3_SH, 32'h0000_0102, 32'h5555_1234, 4'b1100, 32'h1234_1234);

    do_load("lb",  F3_LB,  32'h0000_0001, 32'h1234_80FF, 5'd5, 1'b0, 32'hFFFF_FF80);
    do_load("lbu", F3_LBU, 32'h0000_0001, 32'h1234_80FF, 5'd6, 1'b0, 32'h0000_0080);
    do_load("lh",  F3_LH,  32'h0000_0002, 32'h8001_0000, 5'd7, 1'b0, 32'hFFFF_8001);
    do_load("lhu", F3_LHU, 32'h0000_0002, 32'h8001_0000, 5'd8, 1'b0, 32'h0000_8001);
    do_load("lw_r0", F3_LW, 32'h0000_0004, 32'hCAFE_F00D, 5'd0, 1'b0, 32'hCAFE_F00D);

    do_reject("lw_mis", 1'b0, F3_LW, 32'h0000_0006);
    check_val("lw_mis_wb_data_kept", wb_data, 32'hCAFE_F00D);
    do_reject("sh_mis", 1'b1, F3_SH, 32'h0000_0001);
    do_reject("ld_f3_3", 1'b0, 3'd3, 32'h0000_0000);
    do_reject("st_f3_4", 1'b1, 3'd4, 32'h0000_0000);

    do_load("io_lw", F3_LW, 32'h0000_0400, 32'h0000_1111, 5'd3, 1'b1, 32'h0000_1111);
    check_val("io_proto_err", {31'd0, proto_err}, 32'd0);
    do_load("ram_fast", F3_LW, 32'h0000_0010, 32'h0000_2222, 5'd4, 1'b1, 32'h0000_2222);
    check_val("ram_proto_err", {31'd0, proto_err}, 32'd1);
    do_load("ram_after", F3_LB, 32'h0000_0013, 32'h7F00_0000, 5'd4, 1'b0, 32'h0000_007F);
    check_val("proto_err_sticky", {31'd0, proto_err}, 32'd1);

    start_req(1'b0, F3_LW, 32'h0000_0020, 32'h0, 5'd11);
    @(negedge clk);
    check_val("midrst_re_wait", {31'd0, mem_re}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    $display("midrst re=%0b ready=%0b wb_valid=%0b proto_err=%0b", mem_re, req_ready, wb_valid, proto_err);
    check_val("midrst_re", {31'd0, mem_re}, 32'd0);
    check_val("midrst_ready", {31'd0, req_ready}, 32'd1);
    check_val("midrst_wb_valid", {31'd0, wb_valid}, 32'd0);
    check_val("midrst_proto_err", {31'd0, proto_err}, 32'd0);
    check_val("midrst_wb_data", wb_data, 32'd0);
    @(negedge clk);
    check_val("midrst_no_late_wb", {31'd0, wb_valid}, 32'd0);
    check_val("midrst_no_misalign", {31'd0, misalign}, 32'd0);
    check_val("midrst_ready2", {31'd0, req_ready}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
